// File: rtl/traffic_pkg.sv
// Shared lamp encodings and monitor enums for the traffic light controller and its safety monitor.
package traffic_pkg;

    localparam int unsigned LAMP_W  = 3;
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned COUNT_W = 8;

    typedef logic [LAMP_W-1:0] lamp_t;

    localparam lamp_t RED    = 3'b100;
    localparam lamp_t YELLOW = 3'b010;
    localparam lamp_t GREEN  = 3'b001;

    typedef enum logic [CODE_W-1:0] {
        FC_NONE          = 3'd0,
        FC_CONFLICT      = 3'd1,
        FC_ENCODING      = 3'd2,
        FC_SEQUENCE      = 3'd3,
        FC_SHORT_YELLOW  = 3'd4,
        FC_TURN_MISMATCH = 3'd5,
        FC_WATCHDOG      = 3'd6
    } fault_code_t;

    typedef enum logic [1:0] {
        ARMING  = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } mon_state_t;

    // True when the lamp bus holds exactly one legal lamp.
    function automatic logic is_lamp(input lamp_t lamp);
        return (lamp == RED) || (lamp == YELLOW) || (lamp == GREEN);
    endfunction

endpackage

// File: rtl/light_sequence_checker.sv
// Per-road lamp history: flags lamp changes, illegal transitions and yellow phases that end too early.
module light_sequence_checker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [LAMP_W-1:0] lamp,
    output logic              changed_c,
    output logic              seq_err_c,
    output logic              short_yellow_c
);

    localparam int unsigned YCNT_W = $clog2(MIN_YELLOW + 1);

    lamp_t             prev;
    logic [YCNT_W-1:0] ycnt;
    logic [YCNT_W-1:0] ycnt_next;
    logic              legal_step;

    always_comb begin
        changed_c      = (lamp != prev);
        legal_step     = ((prev == GREEN)  && (lamp == YELLOW)) ||
                         ((prev == YELLOW) && (lamp == RED))    ||
                         ((prev == RED)    && (lamp == GREEN));
        seq_err_c      = changed_c && !legal_step;
        short_yellow_c = (prev == YELLOW) && (lamp == RED) && (ycnt < YCNT_W'(MIN_YELLOW));
    end

    // Counts consecutive sampled yellow cycles, saturating once the minimum is met.
    always_comb begin
        ycnt_next = '0;
        if (clear) begin
            ycnt_next = '0;
        end else if (lamp != YELLOW) begin
            ycnt_next = '0;
        end else if (prev != YELLOW) begin
            ycnt_next = YCNT_W'(1);
        end else if (ycnt < YCNT_W'(MIN_YELLOW)) begin
            ycnt_next = ycnt + YCNT_W'(1);
        end else begin
            ycnt_next = ycnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= RED;
            ycnt <= '0;
        end else begin
            prev <= lamp;
            ycnt <= ycnt_next;
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor: latches the first lamp violation and forces flashing red until cleared.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 3,
    parameter int unsigned WATCHDOG   = 200,
    parameter int unsigned FLASH_HALF = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [LAMP_W-1:0]  main_road,
    input  logic [LAMP_W-1:0]  side_road,
    input  logic               main_turn_left,
    input  logic               side_turn_left,
    input  logic               fault_clear,
    output logic               fault,
    output logic [CODE_W-1:0]  fault_code,
    output logic               flash_red,
    output logic               monitor_active,
    output logic [COUNT_W-1:0] fault_count
);

    localparam int unsigned WD_W = 8;
    localparam int unsigned FL_W = $clog2(FLASH_HALF + 1);

    mon_state_t  state;
    mon_state_t  state_next;
    fault_code_t code_c;

    logic            main_chg_c, main_seq_c, main_sy_c;
    logic            side_chg_c, side_seq_c, side_sy_c;
    logic            clear_c;
    logic            any_chg_c;
    logic            conflict_c;
    logic            encoding_c;
    logic            turn_c;
    logic            start_c;
    logic            wd_reach_c;
    logic            wd_hit_c;
    logic            enter_fault_c;
    logic [WD_W-1:0] wd_cnt;
    logic [FL_W-1:0] flash_cnt;

    assign clear_c = (state == FAULT) && fault_clear;

    light_sequence_checker #(.MIN_YELLOW(MIN_YELLOW)) u_main_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear_c),
        .lamp           (main_road),
        .changed_c      (main_chg_c),
        .seq_err_c      (main_seq_c),
        .short_yellow_c (main_sy_c)
    );

    light_sequence_checker #(.MIN_YELLOW(MIN_YELLOW)) u_side_seq (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (clear_c),
        .lamp           (side_road),
        .changed_c      (side_chg_c),
        .seq_err_c      (side_seq_c),
        .short_yellow_c (side_sy_c)
    );

    // Stateless checks on the current sample; the watchdog only survives a quiet cycle in MONITOR.
    always_comb begin
        any_chg_c  = main_chg_c || side_chg_c;
        conflict_c = (main_road != RED) && (side_road != RED);
        encoding_c = !is_lamp(main_road) || !is_lamp(side_road);
        turn_c     = (main_turn_left != (main_road == RED)) ||
                     (side_turn_left != (side_road == RED));
        start_c    = (main_road == GREEN) && (side_road == RED);
        wd_reach_c = ((WD_W + 1)'(wd_cnt) + (WD_W + 1)'(1)) == (WD_W + 1)'(WATCHDOG);
        wd_hit_c   = wd_reach_c && !((state == MONITOR) && any_chg_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARMING;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus priority encode: the lowest numbered violation wins.
    always_comb begin
        state_next = state;
        code_c     = FC_NONE;
        case (state)
            ARMING: begin
                if (conflict_c) begin
                    code_c = FC_CONFLICT;
                end else if (encoding_c) begin
                    code_c = FC_ENCODING;
                end else if (start_c) begin
                    state_next = MONITOR;
                end else if (wd_hit_c) begin
                    code_c = FC_WATCHDOG;
                end
            end
            MONITOR: begin
                if (conflict_c) begin
                    code_c = FC_CONFLICT;
                end else if (encoding_c) begin
                    code_c = FC_ENCODING;
                end else if (main_seq_c || side_seq_c) begin
                    code_c = FC_SEQUENCE;
                end else if (main_sy_c || side_sy_c) begin
                    code_c = FC_SHORT_YELLOW;
                end else if (turn_c) begin
                    code_c = FC_TURN_MISMATCH;
                end else if (wd_hit_c) begin
                    code_c = FC_WATCHDOG;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_next = ARMING;
                end
            end
            default: begin
                state_next = ARMING;
            end
        endcase
        if (code_c != FC_NONE) begin
            state_next = FAULT;
        end
    end

    assign enter_fault_c = (state != FAULT) && (state_next == FAULT);

    // Idle/arming timer restarts on every state change and on any lamp change while monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if ((state_next != state) || (state == FAULT)) begin
            wd_cnt <= '0;
        end else if ((state == MONITOR) && any_chg_c) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // Registered outputs, fault code latch, flash timer and saturating fault counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault          <= 1'b0;
            monitor_active <= 1'b0;
            fault_code     <= '0;
            flash_red      <= 1'b0;
            flash_cnt      <= '0;
            fault_count    <= '0;
        end else begin
            fault          <= (state_next == FAULT);
            monitor_active <= (state_next == MONITOR);
            if (enter_fault_c) begin
                fault_code <= code_c;
                flash_red  <= 1'b1;
                flash_cnt  <= '0;
                if (fault_count != {COUNT_W{1'b1}}) begin
                    fault_count <= fault_count + COUNT_W'(1);
                end
            end else if (state_next == FAULT) begin
                if (flash_cnt == FL_W'(FLASH_HALF - 1)) begin
                    flash_red <= ~flash_red;
                    flash_cnt <= '0;
                end else begin
                    flash_cnt <= flash_cnt + FL_W'(1);
                end
            end else begin
                fault_code <= '0;
                flash_red  <= 1'b0;
                flash_cnt  <= '0;
            end
        end
    end

endmodule
